data_mem_responder: RTL and testbench

//   Memory-side responder for the 12-bit CPU's data bus: accepts load/store requests and answers with a one-cycle ack.

---
 rtl/data_mem_responder.sv | 157 +++++++++++++++
 tb/tb_data_mem_responder.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/data_mem_responder.sv
// Data-bus memory responder: internal word store for loads/stores, byte-style address -> word index; MMIO_PORT_EN adds an io_out register at 12'hFFC.
// Latency: request accepted on edge k, ack/err in the cycle after edge k+1+WAIT_CYCLES (WAIT_CYCLES=0: the cycle right after edge k).
// Backpressure: one request in flight; req is not sampled while busy or in the ack cycle, so acks are at least one idle cycle apart.
module data_mem_responder #(
  parameter int DATA_W      = 12,
  parameter int ADDR_W      = 12,
  parameter int DEPTH       = 64,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              ack,
  output logic              busy,
  output logic              err
`ifdef MMIO_PORT_EN
  ,
  output logic [DATA_W-1:0] io_out
`endif
);

  localparam int         IDXW     = ADDR_W - 2;
  localparam int         MW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t            state_q, state_d;
  logic [3:0]        cnt_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              err_q;
  logic [DATA_W-1:0] mem [DEPTH];

  logic              accept;
  logic              go_resp;
  logic              cur_we;
  logic [ADDR_W-1:0] cur_addr;
  logic [DATA_W-1:0] cur_wdata;
  logic [IDXW-1:0]   cur_idx;
  logic              cur_in_range;
  logic              cur_io;
  logic              cur_hit;
  logic [DATA_W-1:0] load_val;
  logic              unused_addr_lsbs;

  // In IDLE the live bus is the request (needed when WAIT_CYCLES=0 commits on the accept edge); afterwards only the latched copy counts.
  assign accept       = (state_q == IDLE) && req;
  assign cur_we       = (state_q == IDLE) ? we    : we_q;
  assign cur_addr     = (state_q == IDLE) ? addr  : addr_q;
  assign cur_wdata    = (state_q == IDLE) ? wdata : wdata_q;
  assign cur_idx      = cur_addr[ADDR_W-1:2];
  assign cur_in_range = ({1'b0, cur_idx} < (IDXW+1)'(DEPTH));
`ifdef MMIO_PORT_EN
  assign cur_io       = (cur_addr == ADDR_W'(12'hFFC));
`else
  assign cur_io       = 1'b0;
`endif
  assign cur_hit          = cur_in_range && !cur_io;
  assign unused_addr_lsbs = ^cur_addr[1:0];

  assign ack  = (state_q == RESP);
  assign busy = (state_q != IDLE);
  assign err  = (state_q == RESP) && err_q;

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next state; the counter is loaded with WAIT_CYCLES and RESP is entered the edge after it reaches zero.
  always_comb begin
    state_d = state_q;
    go_resp = 1'b0;
    case (state_q)
      IDLE: begin
        if (req) begin
          if (WAIT_CYCLES == 0) begin
            state_d = RESP;
            go_resp = 1'b1;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = RESP;
          go_resp = 1'b1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Wait-state counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                             cnt_q <= 4'd0;
    else if (accept)                          cnt_q <= CNT_LOAD;
    else if (state_q == WAIT && cnt_q != 0)   cnt_q <= cnt_q - 4'd1;
  end

  // Capture the request on accept so later bus changes are ignored.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (accept) begin
      we_q    <= we;
      addr_q  <= addr;
      wdata_q <= wdata;
    end
  end

  // Error flag for the pending response: out of range and not the MMIO register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)     err_q <= 1'b0;
    else if (go_resp) err_q <= !cur_in_range && !cur_io;
  end

  // Word array, not reset; reset_n gates the write so an aborted request never commits.
  always_ff @(posedge clk) begin
    if (reset_n && go_resp && cur_we && cur_hit) mem[cur_idx[MW-1:0]] <= cur_wdata;
  end

`ifdef MMIO_PORT_EN
  // MMIO output register, written by a store to 12'hFFC.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                         io_out <= '0;
    else if (go_resp && cur_we && cur_io) io_out <= cur_wdata;
  end
`endif

  // Load data source: array word, MMIO register, or zero when out of range.
  always_comb begin
    load_val = '0;
    if (cur_hit) load_val = mem[cur_idx[MW-1:0]];
`ifdef MMIO_PORT_EN
    if (cur_io) load_val = io_out;
`endif
  end

  // Load data is registered on the edge entering RESP and held until the next load.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                 rdata <= '0;
    else if (go_resp && !cur_we)  rdata <= load_val;
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: directed scenarios plus random load/store traffic against a word-array model.
// Ack position is predicted from WAIT_CYCLES; bus inputs are scrambled after accept to prove latching.
// Runs in either build; the MMIO register checks are compiled only with MMIO_PORT_EN.
module tb_data_mem_responder;
  localparam int DATA_W      = 12;
  localparam int ADDR_W      = 12;
  localparam int DEPTH       = 64;
  localparam int WAIT_CYCLES = 2;
  // Negedges after the accept edge until the ack cycle.
  localparam int LAT = (WAIT_CYCLES == 0) ? 1 : WAIT_CYCLES + 2;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              req = 1'b0;
  logic              we = 1'b0;
  logic [ADDR_W-1:0] addr = '0;
  logic [DATA_W-1:0] wdata = '0;
  logic [DATA_W-1:0] rdata;
  logic              ack, busy, err;
`ifdef MMIO_PORT_EN
  logic [DATA_W-1:0] io_out;
`endif

  int checks = 0;
  int errors = 0;
  logic [DATA_W-1:0] mdl [int];
  logic [DATA_W-1:0] io_mdl  = '0;
  logic [DATA_W-1:0] last_rd = '0;

  always #5 clk = ~clk;

  data_mem_responder #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .WAIT_CYCLES(WAIT_CYCLES)) dut (
    .clk(clk), .reset_n(reset_n), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .rdata(rdata), .ack(ack), .busy(busy), .err(err)
`ifdef MMIO_PORT_EN
    , .io_out(io_out)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One transaction; returns at the negedge of the ack cycle. hold keeps req and the bus steady throughout.
  task automatic txn(input logic w, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d, input bit hold);
    int idx, m;
    bit io, oor, got;
    logic [DATA_W-1:0] exp_rd;
    idx = int'(a >> 2);
    io  = 1'b0;
`ifdef MMIO_PORT_EN
    io  = (a == 12'hFFC);
`endif
    oor = !io && (idx >= DEPTH);
    @(posedge clk); #1;
    chk("idle_ack", ack, 0);
    chk("idle_busy", busy, 0);
    req = 1'b1; we = w; addr = a; wdata = d;
    @(posedge clk); #1;
    if (!hold) begin
      req   = 1'($urandom_range(0, 1));
      we    = ~w;
      addr  = ADDR_W'($urandom);
      wdata = DATA_W'($urandom);
    end
    if (w) begin
      exp_rd = last_rd;
      if (io) io_mdl = d;
      else if (!oor) mdl[idx] = d;
    end else begin
      if (io)       exp_rd = io_mdl;
      else if (oor) exp_rd = '0;
      else          exp_rd = mdl.exists(idx) ? mdl[idx] : 'x;
      last_rd = exp_rd;
    end
    got = 1'b0;
    m   = 0;
    while (!got && m < LAT + 8) begin
      @(negedge clk);
      m++;
      chk("busy_in_flight", busy, 1);
      if (ack) got = 1'b1;
    end
    chk("ack_seen", got, 1);
    chk("ack_latency", m, LAT);
    chk("err", err, oor);
    if (exp_rd !== 'x) chk("rdata", rdata, exp_rd);
`ifdef MMIO_PORT_EN
    chk("io_out", io_out, io_mdl);
`endif
    if (!hold) req = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset, then the first cycle after release must be idle with cleared outputs.
    repeat (3) @(posedge clk);
    @(negedge clk); reset_n = 1'b1;
    @(negedge clk);
    chk("rst_rdata", rdata, 0);
    chk("rst_ack", ack, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
`ifdef MMIO_PORT_EN
    chk("rst_io_out", io_out, 0);
`endif

    // Give every word a known value.
    for (int i = 0; i < DEPTH; i++) txn(1'b1, ADDR_W'(i * 4), DATA_W'($urandom), 1'b0);

    // Store then load at 12'h010.
    txn(1'b1, 12'h010, 12'h5A3, 1'b0);
    txn(1'b0, 12'h010, 12'h000, 1'b0);
    chk("load_5a3", rdata, 12'h5A3);

    // Out-of-range load, then an ordinary load.
    txn(1'b0, 12'h100, 12'h000, 1'b0);
    txn(1'b0, 12'h000, 12'h000, 1'b0);

    // Three stores with req held high throughout, then read them back.
    txn(1'b1, 12'h040, 12'h111, 1'b1);
    txn(1'b1, 12'h044, 12'h222, 1'b1);
    txn(1'b1, 12'h048, 12'h333, 1'b1);
    req = 1'b0;
    txn(1'b0, 12'h040, 12'h000, 1'b0);
    txn(1'b0, 12'h045, 12'h000, 1'b0);
    txn(1'b0, 12'h04B, 12'h000, 1'b0);

    // Random traffic: in-range stores/loads with random low address bits, plus out-of-range accesses.
    for (int i = 0; i < 60; i++) begin
      int r;
      r = int'($urandom_range(0, 9));
      if (r < 4)      txn(1'b1, ADDR_W'($urandom_range(0, 255)), DATA_W'($urandom), 1'b0);
      else if (r < 8) txn(1'b0, ADDR_W'($urandom_range(0, 255)), '0, 1'b0);
      else            txn(1'(r & 1), ADDR_W'($urandom_range(256, 4095)), DATA_W'($urandom), 1'b0);
    end

    // Reset during the wait states of a store: nothing commits, no ack, FSM idle.
    @(posedge clk); #1;
    req = 1'b1; we = 1'b1; addr = 12'h020; wdata = 12'hABC;
    @(posedge clk); #1;
    req = 1'b0;
    @(negedge clk);
    chk("abort_busy_before", busy, 1);
    reset_n = 1'b0;
    #1;
    chk("abort_busy_async", busy, 0);
    @(negedge clk); reset_n = 1'b1;
    last_rd = '0;
    io_mdl  = '0;
    for (int i = 0; i < LAT + 3; i++) begin
      @(negedge clk);
      chk("abort_no_ack", ack, 0);
      chk("abort_idle", busy, 0);
    end
    chk("abort_rdata_rst", rdata, 0);
    txn(1'b0, 12'h020, 12'h000, 1'b0);

`ifdef MMIO_PORT_EN
    // MMIO register store and load-back.
    txn(1'b1, 12'hFFC, 12'h0F0, 1'b0);
    chk("mmio_io_out", io_out, 12'h0F0);
    txn(1'b0, 12'hFFC, 12'h000, 1'b0);
    chk("mmio_rdata", rdata, 12'h0F0);
`endif

    @(posedge clk); #1;
    chk("end_ack", ack, 0);
    chk("end_busy", busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
